// File: rtl/mc_pkg.sv
// mc_pkg: shared states, opcodes, ALU codes and datapath select codes for the multicycle controller
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    localparam logic [1:0] SA_PC    = 2'b00;
    localparam logic [1:0] SA_OLDPC = 2'b01;
    localparam logic [1:0] SA_RS1   = 2'b10;

    localparam logic [1:0] SB_RS2  = 2'b00;
    localparam logic [1:0] SB_IMM  = 2'b01;
    localparam logic [1:0] SB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: maps ALUOp plus funct3/funct7b5 to the ALUControl code
module mc_aludec
    import mc_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    // Subtract only for R-type with funct7b5; unknown funct3 falls back to add
    always_comb begin
        alu_control = ALU_ADD;
        if (aluop == ALUOP_SUB)
            alu_control = ALU_SUB;
        else if (aluop == ALUOP_FUNCT)
            case (funct3)
                3'b000:  alu_control = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
                3'b010:  alu_control = ALU_SLT;
                3'b110:  alu_control = ALU_OR;
                3'b111:  alu_control = ALU_AND;
                default: alu_control = ALU_ADD;
            endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle RV32I-subset main controller; MC_PERF_CNT_EN adds instret/cycles counters
module mc_controller
    import mc_pkg::*;
`ifdef MC_PERF_CNT_EN
#(
    parameter int CNT_WIDTH = 32
)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal,
    output logic [3:0] state
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] instret,
    output logic [CNT_WIDTH-1:0] cycles
`endif
);

    state_t state_q, state_d;
    aluop_t aluop;
    logic   pcw, irw, rw, mw;

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk or negedge reset)
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;

    // Next state; memory states stall on mem_ready, unknown opcodes and codes trap
    always_comb begin
        state_d = TRAP;
        case (state_q)
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE:   state_d = (op == OP_LW || op == OP_SW) ? MEMADR :
                                (op == OP_R)   ? EXECUTER :
                                (op == OP_I)   ? EXECUTEI :
                                (op == OP_JAL) ? JAL :
                                (op == OP_BEQ) ? BEQ : TRAP;
            MEMADR:   state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = mem_ready ? FETCH : MEMWRITE;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            JAL:      state_d = ALUWB;
            BEQ:      state_d = FETCH;
            default:  state_d = TRAP;
        endcase
    end

    // Moore output decode; FETCH enables follow mem_ready and BEQ's PC write follows Zero
    always_comb begin
        pcw       = 1'b0;
        irw       = 1'b0;
        rw        = 1'b0;
        mw        = 1'b0;
        AdrSrc    = ADR_PC;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SA_PC;
        ALUSrcB   = SB_RS2;
        aluop     = ALUOP_ADD;
        illegal   = 1'b0;
        case (state_q)
            FETCH:    begin ALUSrcB = SB_FOUR; ResultSrc = RES_ALURESULT; pcw = mem_ready; irw = mem_ready; end
            DECODE:   begin ALUSrcA = SA_OLDPC; ALUSrcB = SB_IMM; end
            MEMADR:   begin ALUSrcA = SA_RS1; ALUSrcB = SB_IMM; end
            MEMREAD:  AdrSrc = ADR_ALUOUT;
            MEMWB:    begin ResultSrc = RES_DATA; rw = 1'b1; end
            MEMWRITE: begin AdrSrc = ADR_ALUOUT; mw = 1'b1; end
            EXECUTER: begin ALUSrcA = SA_RS1; aluop = ALUOP_FUNCT; end
            EXECUTEI: begin ALUSrcA = SA_RS1; ALUSrcB = SB_IMM; aluop = ALUOP_FUNCT; end
            ALUWB:    rw = 1'b1;
            JAL:      begin ALUSrcA = SA_OLDPC; ALUSrcB = SB_FOUR; pcw = 1'b1; end
            BEQ:      begin ALUSrcA = SA_RS1; aluop = ALUOP_SUB; pcw = Zero; end
            TRAP:     illegal = 1'b1;
            default:  ;
        endcase
    end

    // Immediate format depends only on the opcode
    always_comb
        ImmSrc = (op == OP_SW)  ? IMM_S :
                 (op == OP_BEQ) ? IMM_B :
                 (op == OP_JAL) ? IMM_J : IMM_I;

    assign PCWrite  = pcw & reset;
    assign IRWrite  = irw & reset;
    assign RegWrite = rw & reset;
    assign MemWrite = mw & reset;
    assign state    = state_q;

    mc_aludec u_aludec (
        .aluop       (aluop),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (ALUControl)
    );

`ifdef MC_PERF_CNT_EN
    logic retire;

    assign retire = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BEQ) ||
                    (state_q == MEMWRITE && mem_ready);

    // Free-running performance counters, frozen once trapped
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            instret <= '0;
            cycles  <= '0;
        end else begin
            if (state_q != TRAP) cycles <= cycles + 1'b1;
            if (retire) instret <= instret + 1'b1;
        end
`endif

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle main controller for the RV32I subset: add, sub, and, or, slt, their immediate forms, lw, sw, beq and jal. It is a Moore state machine that sequences a shared-memory multicycle datapath, taking one instruction through fetch, decode, execute, memory access and writeback over 3–5 cycles. Memory accesses stall on a ready handshake, and an unknown opcode sends the core to a sticky trap state. It replaces the single-cycle controller when the core moves to one unified memory.

## Interface
- CNT_WIDTH, 32: width of the performance counters (used only with MC_PERF_CNT_EN).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- op  in  7  opcode, taken from the instruction register (IR).
- funct3  in  3  IR[14:12].
- funct7b5  in  1  IR[30].
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current access this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR and OldPC register enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU input A select: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  ALU input B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- illegal  out  1  sticky flag, set while in TRAP.
- state  out  4  current state encoding, for debug.
- instret, cycles  out  CNT_WIDTH each  retired-instruction and cycle counters (present only with MC_PERF_CNT_EN).

## Operation
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10, TRAP 11. Codes 12–15 are unreachable and go to TRAP.
- Controls that are not listed for a state are 0 in that state.
- FETCH
  - Drives AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp add, ResultSrc=10.
  - IRWrite and PCWrite are asserted only in a cycle where mem_ready=1.
  - Moves to DECODE on mem_ready; otherwise stays in FETCH.
- DECODE
  - Drives ALUSrcA=01, ALUSrcB=01, add. This computes the branch/jump target OldPC+imm.
  - Next state by opcode: 0000011 or 0100011 → MEMADR; 0110011 → EXECUTER; 0010011 → EXECUTEI; 1101111 → JAL; 1100011 → BEQ; any other opcode → TRAP.
- MEMADR: drives ALUSrcA=10, ALUSrcB=01, add. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD
  - Drives AdrSrc=1.
  - Holds until mem_ready, then goes to MEMWB.
- MEMWB: drives ResultSrc=01, RegWrite=1, then goes to FETCH.
- MEMWRITE
  - Drives AdrSrc=1, MemWrite=1 for every cycle until mem_ready. Memory commits the write on the ready cycle.
  - Goes to FETCH on mem_ready.
- EXECUTER: drives ALUSrcA=10, ALUSrcB=00, ALUOp funct; goes to ALUWB.
- EXECUTEI: drives ALUSrcA=10, ALUSrcB=01, ALUOp funct; goes to ALUWB.
- ALUWB: drives ResultSrc=00, RegWrite=1, then goes to FETCH.
- JAL
  - Drives ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1. The PC receives the target held in ALUOut, and the ALU computes OldPC+4 for the link.
  - Goes to ALUWB.
- BEQ
  - Drives ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=Zero.
  - Goes to FETCH.
- TRAP: all enables 0 and illegal=1. Only reset leaves TRAP.
- ImmSrc is decoded combinationally from op in every state: lw/I-type 00, sw 01, beq 10, jal 11, otherwise 00.
- ALU decode
  - ALUOp add gives 000; ALUOp sub gives 001.
  - ALUOp funct decodes funct3: 000 gives sub only if funct7b5 and op[5] are both 1, else add; 010 gives slt; 110 gives or; 111 gives and.
  - Any other funct3 under ALUOp funct gives 000 and does not trap.

## Timing
- Reset low
  - State becomes FETCH immediately (asynchronous) and illegal becomes 0.
  - PCWrite, IRWrite, RegWrite and MemWrite are forced to 0 while reset is low.
  - Counters clear to 0.
- The first FETCH cycle is the first rising edge after reset goes high.
- Cycles per instruction with mem_ready tied high: beq 3; R-type, I-type, sw and jal 4; lw 5.
- Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle, and all outputs hold steady.
- mem_ready is ignored in every other state.
- If reset asserts mid-instruction, the instruction is abandoned. Any pending write is dropped unless mem_ready was already high on that edge.
- All outputs are Moore outputs, except PCWrite in BEQ (uses Zero) and IRWrite/PCWrite in FETCH (use mem_ready).

## Configuration
- MC_PERF_CNT_EN defined:
  - cycles increments on every clock edge while out of reset and not in TRAP.
  - instret increments on each exit from MEMWB, ALUWB, BEQ, or MEMWRITE with mem_ready.
  - Both counters wrap modulo 2^CNT_WIDTH.
- MC_PERF_CNT_EN undefined: the instret and cycles ports and their registers do not exist.

## Structure
- Package mc_pkg holds:
  - the state enum;
  - opcode localparams (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ);
  - the ALUControl codes;
  - the select-code localparams for AdrSrc, ALUSrcA/B and ResultSrc.
- One sub-module, mc_aludec: combinational ALUOp/funct to ALUControl decoder. The state register, next-state logic and output decode live in mc_controller.

## Test plan
- Reset behaviour: hold reset low mid-MEMWRITE with MemWrite=1 → MemWrite drops to 0 in the same cycle and state=0; after release, FETCH with IRWrite=1.
- lw with wait states: op=0000011, mem_ready low for 2 cycles in both FETCH and MEMREAD → 9 cycles total, exactly one IRWrite pulse, RegWrite high only in MEMWB with ResultSrc=01.
- beq: op=1100011 with Zero=1 → PCWrite=1 in cycle 3 with ALUControl=001; with Zero=0 → PCWrite=0; back to FETCH in both cases.
- R-type sub vs addi: op=0110011, funct3=000, funct7b5=1 → ALUControl=001 in EXECUTER. op=0010011 with funct7b5=1 → 000.
- jal: op=1101111 → JAL state with PCWrite=1, ImmSrc=11, then ALUWB with RegWrite=1 and ResultSrc=00; 4 cycles total.
- Illegal opcode and counters: op=0000000 → TRAP, illegal=1, all enables 0 for 20 cycles. With MC_PERF_CNT_EN, after 3 R-type instructions plus one beq, instret=4 and cycles=15.
